// File: rtl/pellet_pkg.sv
// Shared codes and helpers for the maze pellet store: sprite, tile and eat-kind
// encodings, the controller state enum and the refill pattern.
package pellet_pkg;

  localparam logic [1:0] SPR_NONE  = 2'd0;
  localparam logic [1:0] SPR_SMALL = 2'd1;
  localparam logic [1:0] SPR_POWER = 2'd3;

  localparam logic [1:0] TILE_EMPTY = 2'b00;
  localparam logic [1:0] TILE_SMALL = 2'b01;
  localparam logic [1:0] TILE_POWER = 2'b11;

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_SMALL = 2'd1;
  localparam logic [1:0] KIND_POWER = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_EAT    = 2'd2
  } state_t;

  // Power pellets sit this many tiles inside each maze corner.
  localparam int PWR_INSET = 1;

  function automatic logic [1:0] refill_tile(input logic [4:0] x, input logic [4:0] y,
                                             input int cols, input int rows);
    logic border;
    logic corner;
    border = (x == 5'd0) || (int'(x) == cols - 1) || (y == 5'd0) || (int'(y) == rows - 1);
    corner = ((int'(x) == PWR_INSET) || (int'(x) == cols - 1 - PWR_INSET)) &&
             ((int'(y) == PWR_INSET) || (int'(y) == rows - 1 - PWR_INSET));
    if (border)      return TILE_EMPTY;
    else if (corner) return TILE_POWER;
    else             return TILE_SMALL;
  endfunction

  function automatic logic [1:0] tile_kind(input logic [1:0] tile);
    if (tile == TILE_SMALL)      return KIND_SMALL;
    else if (tile == TILE_POWER) return KIND_POWER;
    else                         return KIND_NONE;
  endfunction

endpackage

// File: rtl/pellet_blink_timer.sv
// Power-pellet blink: counts frame ticks and toggles the phase every
// BLINK_FRAMES ticks. Phase starts "on" out of reset.
module pellet_blink_timer #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  output logic blink_on
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_reg;
  logic          on_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      on_reg  <= 1'b1;
    end else if (frame_tick) begin
      if (cnt_reg == CW'(BLINK_FRAMES - 1)) begin
        cnt_reg <= '0;
        on_reg  <= ~on_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign blink_on = on_reg;

endmodule

// File: rtl/pellet_map_ctrl.sv
// Pellet store owner: arbitrates one single-ported tile RAM between video
// lookup (highest priority), the level refill sweep and eat requests.
module pellet_map_ctrl
  import pellet_pkg::*;
#(
  parameter int COLS         = 28,
  parameter int ROWS         = 31,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       vid_active,
  input  logic [4:0] vid_tile_x,
  input  logic [4:0] vid_tile_y,
  output logic [1:0] vid_sprite,
  input  logic       refill_start,
  output logic       busy,
  input  logic       eat_req,
  input  logic [4:0] eat_x,
  input  logic [4:0] eat_y,
  output logic       eat_ack,
  output logic [1:0] eat_kind,
  output logic [9:0] pellet_count,
  output logic       all_eaten
);

  localparam int NTILES = COLS * ROWS;
  localparam int AW     = $clog2(NTILES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NTILES - 1);

  function automatic logic [AW-1:0] tile_idx(input logic [4:0] x, input logic [4:0] y);
    return AW'(int'(y) * COLS + int'(x));
  endfunction

  state_t        state_reg, state_next;
  logic [AW-1:0] refill_addr_reg;
  logic [4:0]    refill_x_reg, refill_y_reg;
  logic [9:0]    count_reg;
  logic          level_valid_reg, all_eaten_reg;
  logic          eat_ack_reg, eat_hit_reg;
  logic          vid_valid_reg, vid_blink_reg;
  logic          blink_on;

  logic [1:0]    mem [NTILES];
  logic [1:0]    rd_data_reg;
  logic          mem_we, refill_write, eat_fire, eat_dec;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_wdata, refill_wdata;

  logic          vid_in_range, eat_in_range;
  logic [AW-1:0] vid_addr, eat_addr;

  assign vid_in_range = (int'(vid_tile_x) < COLS) && (int'(vid_tile_y) < ROWS);
  assign eat_in_range = (int'(eat_x) < COLS) && (int'(eat_y) < ROWS);
  assign vid_addr     = vid_in_range ? tile_idx(vid_tile_x, vid_tile_y) : '0;
  assign eat_addr     = eat_in_range ? tile_idx(eat_x, eat_y) : '0;
  assign refill_wdata = refill_tile(refill_x_reg, refill_y_reg, COLS, ROWS);

  pellet_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .blink_on   (blink_on)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Refill always wins; an eat in progress simply stays pending on eat_req.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (refill_start)                                state_next = ST_REFILL;
        else if (eat_req && !vid_active && !eat_ack_reg) state_next = ST_EAT;
      end
      ST_REFILL: begin
        if (refill_start)                                   state_next = ST_REFILL;
        else if (!vid_active && refill_addr_reg == LAST_IDX) state_next = ST_IDLE;
      end
      ST_EAT: begin
        if (refill_start)     state_next = ST_REFILL;
        else if (!vid_active) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_reg == ST_REFILL);
    mem_addr     = vid_addr;
    mem_we       = 1'b0;
    mem_wdata    = TILE_EMPTY;
    refill_write = 1'b0;
    eat_fire     = 1'b0;
    if (!vid_active && !refill_start) begin
      unique case (state_reg)
        ST_REFILL: begin
          mem_addr     = refill_addr_reg;
          mem_we       = 1'b1;
          mem_wdata    = refill_wdata;
          refill_write = 1'b1;
        end
        ST_EAT: begin
          mem_addr = eat_addr;
          mem_we   = eat_in_range;
          eat_fire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read-first RAM: an eat sees the old tile while clearing it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_data_reg <= mem[mem_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refill_addr_reg <= '0;
      refill_x_reg    <= '0;
      refill_y_reg    <= '0;
      count_reg       <= '0;
      level_valid_reg <= 1'b0;
      all_eaten_reg   <= 1'b0;
      eat_ack_reg     <= 1'b0;
      eat_hit_reg     <= 1'b0;
      vid_valid_reg   <= 1'b0;
      vid_blink_reg   <= 1'b1;
    end else begin
      eat_ack_reg   <= eat_fire;
      // Before any completed refill the store is undefined, so eats report nothing.
      eat_hit_reg   <= eat_fire && eat_in_range && level_valid_reg;
      vid_valid_reg <= vid_active && vid_in_range;
      vid_blink_reg <= blink_on;
      all_eaten_reg <= level_valid_reg && (count_reg == 10'd0);
      if (refill_start) begin
        refill_addr_reg <= '0;
        refill_x_reg    <= '0;
        refill_y_reg    <= '0;
        count_reg       <= '0;
        level_valid_reg <= 1'b0;
      end else begin
        if (refill_write) begin
          if (refill_wdata != TILE_EMPTY) count_reg <= count_reg + 10'd1;
          if (refill_addr_reg == LAST_IDX) level_valid_reg <= 1'b1;
          refill_addr_reg <= refill_addr_reg + 1'b1;
          if (refill_x_reg == 5'(COLS - 1)) begin
            refill_x_reg <= '0;
            refill_y_reg <= refill_y_reg + 5'd1;
          end else begin
            refill_x_reg <= refill_x_reg + 5'd1;
          end
        end
        if (eat_dec) count_reg <= count_reg - 10'd1;
      end
    end
  end

  always_comb begin
    vid_sprite = SPR_NONE;
    if (vid_valid_reg) begin
      if (rd_data_reg == TILE_SMALL)                       vid_sprite = SPR_SMALL;
      else if (rd_data_reg == TILE_POWER && vid_blink_reg) vid_sprite = SPR_POWER;
    end
  end

  assign eat_kind     = (eat_ack_reg && eat_hit_reg) ? tile_kind(rd_data_reg) : KIND_NONE;
  assign eat_dec      = eat_ack_reg && (eat_kind != KIND_NONE) && !refill_start;
  assign eat_ack      = eat_ack_reg;
  assign pellet_count = count_reg;
  assign all_eaten    = all_eaten_reg;

  pellet_count_no_underflow: assert property (
    @(posedge clk) disable iff (reset) !(eat_dec && count_reg == 10'd0));

endmodule

// File: tb/tb_pellet_map_ctrl.sv
// Self-checking bench for pellet_map_ctrl: directed scenarios plus random
// video/eat traffic, compared each cycle against a tile-array model.
module tb_pellet_map_ctrl;

  localparam int COLS = 28;
  localparam int ROWS = 31;
  localparam int BF   = 8;
  localparam int N    = COLS * ROWS;
  localparam int M_IDLE = 0, M_REFILL = 1, M_EAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       vid_active = 1'b0;
  logic [4:0] vid_tile_x = '0, vid_tile_y = '0;
  logic [1:0] vid_sprite;
  logic       refill_start = 1'b0;
  logic       busy;
  logic       eat_req = 1'b0;
  logic [4:0] eat_x = '0, eat_y = '0;
  logic       eat_ack;
  logic [1:0] eat_kind;
  logic [9:0] pellet_count;
  logic       all_eaten;

  pellet_map_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .vid_active(vid_active), .vid_tile_x(vid_tile_x), .vid_tile_y(vid_tile_y),
    .vid_sprite(vid_sprite), .refill_start(refill_start), .busy(busy),
    .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y), .eat_ack(eat_ack),
    .eat_kind(eat_kind), .pellet_count(pellet_count), .all_eaten(all_eaten)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tiles hold -1 (unknown), 0 empty, 1 small, 3 power.
  int tiles [N];
  int m_mode, m_ptr, m_count, m_ticks, m_kind, exp_sprite;
  bit m_level, m_ack, exp_all;

  function automatic int pattern(input int i);
    int x, y;
    x = i % COLS;
    y = i / COLS;
    if (x == 0 || y == 0 || x == COLS - 1 || y == ROWS - 1) return 0;
    if ((x == 1 || x == COLS - 2) && (y == 1 || y == ROWS - 2)) return 3;
    return 1;
  endfunction

  function automatic bit blink_phase_on();
    return ((m_ticks / BF) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ptr = 0; m_count = 0; m_ticks = 0; m_kind = 0;
    m_level = 1'b0; m_ack = 1'b0; exp_sprite = 0; exp_all = 1'b0;
  endtask

  task automatic model_step();
    int vx, vy, ex, ey, t, nsprite, nkind;
    bit nack, nall;
    vx = int'(vid_tile_x); vy = int'(vid_tile_y);
    ex = int'(eat_x);      ey = int'(eat_y);
    nall = m_level && (m_count == 0);
    nsprite = 0;
    if (vid_active && vx < COLS && vy < ROWS) begin
      t = tiles[vy * COLS + vx];
      if (t < 0)                             nsprite = -1;
      else if (t == 1)                       nsprite = 1;
      else if (t == 3 && blink_phase_on())   nsprite = 3;
    end
    if (frame_tick) m_ticks++;
    if (m_ack && !refill_start && m_kind != 0) m_count--;
    nack = 1'b0; nkind = 0;
    if (refill_start) begin
      m_mode = M_REFILL; m_ptr = 0; m_count = 0; m_level = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (eat_req && !vid_active && !m_ack) m_mode = M_EAT;
    end else if (m_mode == M_REFILL) begin
      if (!vid_active) begin
        tiles[m_ptr] = pattern(m_ptr);
        if (tiles[m_ptr] != 0) m_count++;
        if (m_ptr == N - 1) begin m_level = 1'b1; m_mode = M_IDLE; end
        m_ptr++;
      end
    end else if (!vid_active) begin
      if (ex < COLS && ey < ROWS) begin
        t = tiles[ey * COLS + ex];
        if (m_level) nkind = (t == 1) ? 1 : (t == 3) ? 2 : 0;
        tiles[ey * COLS + ex] = 0;
      end
      nack = 1'b1;
      m_mode = M_IDLE;
    end
    m_ack = nack; m_kind = nkind; exp_sprite = nsprite; exp_all = nall;
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      if (exp_sprite >= 0) check("vid_sprite", int'(vid_sprite), exp_sprite);
      check("busy", int'(busy), int'(m_mode == M_REFILL));
      check("eat_ack", int'(eat_ack), int'(m_ack));
      check("eat_kind", int'(eat_kind), m_kind);
      check("pellet_count", int'(pellet_count), m_count);
      check("all_eaten", int'(all_eaten), int'(exp_all));
    end
  end

  task automatic vid_probe(input int x, input int y, output int s);
    @(negedge clk);
    vid_active = 1'b1; vid_tile_x = 5'(x); vid_tile_y = 5'(y);
    @(negedge clk);
    s = int'(vid_sprite);
    vid_active = 1'b0;
  endtask

  task automatic tick_frames(input int n);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_eat(input int x, input int y, output int lat, output int kind);
    eat_x = 5'(x); eat_y = 5'(y); eat_req = 1'b1;
    lat = 0; kind = -1;
    do begin @(negedge clk); lat++; end while (!eat_ack && lat < 200);
    if (!eat_ack) begin
      errors++;
      $display("FAIL eat_timeout: got no ack required ack at (%0d,%0d)", x, y);
    end else kind = int'(eat_kind);
    eat_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_refill(output int cycles);
    @(negedge clk); refill_start = 1'b1;
    @(negedge clk); refill_start = 1'b0;
    cycles = 0;
    while (busy && cycles < 5000) begin cycles++; @(negedge clk); end
  endtask

  initial begin
    int n, s, lat, kind;
    bit saw_busy;
    foreach (tiles[i]) tiles[i] = -1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_vid_sprite", int'(vid_sprite), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_eat_ack", int'(eat_ack), 0);
    check("rst_eat_kind", int'(eat_kind), 0);
    check("rst_pellet_count", int'(pellet_count), 0);
    check("rst_all_eaten", int'(all_eaten), 0);
    chk_en = 1'b1;

    run_refill(n);
    check("refill_busy_cycles", n, 868);
    check("refill_count", int'(pellet_count), 754);
    check("refill_all_eaten", int'(all_eaten), 0);

    vid_probe(5, 5, s);   check("vid_small_5_5", s, 1);
    vid_probe(1, 1, s);   check("vid_power_on", s, 3);
    tick_frames(8);
    vid_probe(1, 1, s);   check("vid_power_off", s, 0);
    vid_probe(0, 0, s);   check("vid_border", s, 0);
    tick_frames(8);
    vid_probe(26, 29, s); check("vid_power_back_on", s, 3);
    vid_probe(30, 5, s);  check("vid_out_of_range", s, 0);

    do_eat(1, 1, lat, kind);
    check("eat_power_latency", lat, 2);
    check("eat_power_kind", kind, 2);
    check("eat_power_count", int'(pellet_count), 753);
    do_eat(1, 1, lat, kind);
    check("eat_again_kind", kind, 0);
    check("eat_again_count", int'(pellet_count), 753);
    do_eat(30, 3, lat, kind);
    check("eat_oob_kind", kind, 0);

    // Eat request starved by video for 50 cycles.
    eat_x = 5'd5; eat_y = 5'd5; eat_req = 1'b1; vid_active = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vid_tile_x = 5'($urandom_range(0, 31)); vid_tile_y = 5'($urandom_range(0, 31));
      check("starved_no_ack", int'(eat_ack), 0);
    end
    vid_active = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!eat_ack && lat < 50);
    check("starved_ack_latency", lat, 2);
    check("starved_kind", int'(eat_kind), 1);
    eat_req = 1'b0;
    @(negedge clk);

    // Refill and eat arriving together: refill first, eat afterwards.
    @(negedge clk);
    refill_start = 1'b1; eat_x = 5'd2; eat_y = 5'd2; eat_req = 1'b1;
    @(negedge clk);
    refill_start = 1'b0;
    saw_busy = 1'b0; n = 0;
    while (!eat_ack && n < 3000) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk); n++;
    end
    check("simul_ack_seen", int'(eat_ack), 1);
    check("simul_refill_ran", int'(saw_busy), 1);
    check("simul_busy_at_ack", int'(busy), 0);
    check("simul_kind", int'(eat_kind), 1);
    eat_req = 1'b0;
    repeat (2) @(negedge clk);
    check("simul_count", int'(pellet_count), 753);

    // Random video, frame ticks and eats against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      vid_active = ($urandom_range(0, 1) == 1);
      vid_tile_x = 5'($urandom_range(0, 31));
      vid_tile_y = 5'($urandom_range(0, 31));
      frame_tick = ($urandom_range(0, 15) == 0);
      if (eat_req && eat_ack) eat_req = 1'b0;
      else if (!eat_req && $urandom_range(0, 3) == 0) begin
        eat_x = 5'($urandom_range(0, 31));
        eat_y = 5'($urandom_range(0, 31));
        eat_req = 1'b1;
      end
    end
    vid_active = 1'b0; frame_tick = 1'b0;
    for (int k = 0; k < 20 && eat_req; k++) begin
      @(negedge clk);
      if (eat_ack) eat_req = 1'b0;
    end
    if (eat_req) begin
      errors++;
      $display("FAIL random_drain: got no ack required ack");
      eat_req = 1'b0;
    end
    @(negedge clk);

    // Clear the whole maze.
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        do_eat(x, y, lat, kind);
        check("eat_all_latency", lat, 2);
      end
    repeat (3) @(negedge clk);
    check("cleared_count", int'(pellet_count), 0);
    check("cleared_all_eaten", int'(all_eaten), 1);

    // Reset in the middle of a refill.
    @(negedge clk); refill_start = 1'b1;
    @(negedge clk); refill_start = 1'b0;
    repeat (100) @(negedge clk);
    check("midrefill_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(pellet_count), 0);
    check("midrst_all_eaten", int'(all_eaten), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pellet_map_ctrl.md
Name: pellet_map_ctrl

Overview:
- Owns the per-tile pellet state of the maze. Sequences the maze-refill sweep at level start and services eat requests from game logic.
- Each cycle, drives the 2-bit sprite code for the current video tile into the pellet bitmap ROM.
- The pellet store is logically single-ported and shared between video lookup, eat requests and refill, so this block also acts as the arbiter for that store.

Parameters:
- COLS, 28, maze width in tiles.
- ROWS, 31, maze height in tiles.
- BLINK_FRAMES, 8, frames per half-period of the power-pellet blink.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- vid_active  in  1  video owns the store this cycle
- vid_tile_x  in  5  video tile column
- vid_tile_y  in  5  video tile row
- vid_sprite  out  2  sprite code to the bitmap ROM: 0 none, 1 small, 3 power
- refill_start  in  1  one-cycle pulse; begin the level refill
- busy  out  1  refill in progress
- eat_req  in  1  request; held high until eat_ack
- eat_x  in  5  tile column to eat; stable while eat_req is high
- eat_y  in  5  tile row to eat; stable while eat_req is high
- eat_ack  out  1  one-cycle completion pulse
- eat_kind  out  2  kind eaten: 0 none, 1 small, 2 power; valid with eat_ack
- pellet_count  out  10  pellets remaining
- all_eaten  out  1  level cleared

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE; vid_sprite=0, busy=0, eat_ack=0, eat_kind=0, pellet_count=0, all_eaten=0.
  - level_valid=0, blink counter=0, blink phase=on.
  - Pellet storage contents are not reset; they are undefined until a refill completes.
- Storage:
  - 2 bits per tile: 00 empty, 01 small, 11 power.
  - Index = y*COLS+x.
  - Coordinates with x>=COLS or y>=ROWS are out of range.
- Video path:
  - vid_sprite is registered, latency 1 cycle from vid_tile_x/y.
  - Forced to 0 when the sampled vid_active=0 or the tile is out of range.
  - A power tile outputs 3 when blink phase is on, 0 when it is off.
  - Video has absolute priority: with vid_active=1, no write or eat access occurs that cycle.
- Blink:
  - The counter increments on frame_tick.
  - On reaching BLINK_FRAMES-1 the counter wraps to 0 and the phase toggles.
- FSM states: IDLE, REFILL, EAT.
- IDLE:
  - refill_start goes to REFILL: addr=0, pellet_count=0, busy=1, level_valid=0.
  - Otherwise, eat_req with vid_active=0 goes to EAT.
  - If refill_start and eat_req arrive together, refill wins; the eat stays pending.
- REFILL:
  - Writes one tile per cycle in which vid_active=0; pauses while vid_active=1.
  - Pattern:
    - border tiles (x=0, x=COLS-1, y=0, y=ROWS-1) empty;
    - (1,1), (COLS-2,1), (1,ROWS-2), (COLS-2,ROWS-2) power;
    - all other tiles small.
  - pellet_count increments on every non-empty tile written.
  - After index COLS*ROWS-1: busy=0, level_valid=1, return to IDLE.
  - refill_start received during REFILL restarts the sweep at 0.
  - Eat requests wait until the refill ends.
  - Defaults: 754 pellets, COLS*ROWS=868 write cycles with no video stalls.
- EAT:
  - Single cycle, entered only with vid_active=0.
  - Reads the tile and clears it to empty. Next cycle: eat_ack=1, with eat_kind 1 (small), 2 (power) or 0 (empty or out of range).
  - pellet_count decrements only on a non-zero kind.
  - Returns to IDLE. A new request is not accepted in the ack cycle.
- all_eaten = level_valid & (pellet_count==0), registered.
- pellet_count never underflows; a decrement at 0 is impossible by construction and is checked by assertion.

Decomposition:
- Package pellet_pkg holds:
  - sprite codes SPR_NONE=0, SPR_SMALL=1, SPR_POWER=3;
  - tile codes and eat-kind codes;
  - the FSM state enum;
  - refill-pattern predicate constants.
- One natural sub-module: pellet_blink_timer (frame_tick counter plus phase toggle).

Test Plan:
- Reset, then refill_start with vid_active=0 -> busy high exactly 868 cycles; then pellet_count=754, all_eaten=0.
- Video read at tile (5,5) -> vid_sprite=1 one cycle later. Tile (1,1) -> 3 in phase on, 0 after 8 frame_ticks. Tile (0,0) -> 0.
- eat_req at (1,1), vid_active=0 -> eat_ack after 2 cycles with kind=2, count 753. Repeat at (1,1) -> kind=0, count unchanged.
- eat_req held while vid_active=1 for 50 cycles -> no ack. Drop vid_active -> ack 2 cycles later.
- refill_start and eat_req in the same cycle -> refill runs first; ack arrives after busy falls; count ends 753.
- Eat all 754 pellets -> all_eaten=1. Assert reset mid-refill -> busy=0, count=0, all_eaten=0 immediately.
